// File: rtl/rans_decoder.sv
// Single-stream rANS decoder: loads a 32-bit state head-first from the byte
// stream, finds each symbol by linear table search, emits it and renormalises.
// Optional macro RANS_DEC_FINAL_CHECK_EN: flags err_o when the final state is
// not the encoder's initial state L.
module rans_decoder #(
  parameter int RESOLUTION   = 10,
  parameter int SYMBOL_WIDTH = 8,
  parameter int STATE_WIDTH  = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    restart_i,
  input  logic                    freq_wr_i,
  input  logic [SYMBOL_WIDTH-1:0] freq_addr_i,
  input  logic [RESOLUTION-1:0]   freq_i,
  input  logic [RESOLUTION-1:0]   cum_freq_i,
  input  logic                    start_i,
  input  logic [31:0]             num_symbols_i,
  input  logic                    in_valid_i,
  input  logic [7:0]              in_data_i,
  output logic                    in_ready_o,
  output logic                    sym_valid_o,
  output logic [SYMBOL_WIDTH-1:0] sym_o,
  input  logic                    sym_ready_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    err_o
);

  localparam int DEPTH = 1 << SYMBOL_WIDTH;
  localparam logic [STATE_WIDTH-1:0]  LOWER   = STATE_WIDTH'(1) << (STATE_WIDTH - 9);
  localparam logic [SYMBOL_WIDTH-1:0] IDX_ONE = SYMBOL_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_LOOKUP, S_OUT, S_RENORM, S_ERR
  } state_e;

  state_e                  state_q;
  logic [STATE_WIDTH-1:0]  x_q;
  logic [31:0]             cnt_q;
  logic [SYMBOL_WIDTH-1:0] idx_q;
  logic [1:0]              nbytes_q;
  logic [SYMBOL_WIDTH-1:0] sym_q;
  logic                    done_q;
  logic                    err_q;

  // Frequency table: no reset, contents only meaningful after host writes.
  logic [RESOLUTION-1:0] freq_mem [DEPTH];
  logic [RESOLUTION-1:0] cum_mem  [DEPTH];

  logic [RESOLUTION-1:0]  freq_rd;
  logic [RESOLUTION-1:0]  cum_rd;
  logic [RESOLUTION-1:0]  slot;
  logic [RESOLUTION:0]    cum_end;
  logic                   match;
  logic                   x_low;
  logic                   byte_acc;
  logic [STATE_WIDTH-1:0] x_shift_d;
  logic [STATE_WIDTH-1:0] x_dec_d;

  // Table write port; only the idle decoder accepts updates, restart takes priority.
  always_ff @(posedge clk_i) begin
    if (freq_wr_i && (state_q == S_IDLE) && !restart_i) begin
      freq_mem[freq_addr_i] <= freq_i;
      cum_mem[freq_addr_i]  <= cum_freq_i;
    end
  end

  // Per-cycle lookup compare, state update candidates and handshake decode.
  always_comb begin
    freq_rd   = freq_mem[idx_q];
    cum_rd    = cum_mem[idx_q];
    slot      = x_q[RESOLUTION-1:0];
    cum_end   = {1'b0, cum_rd} + {1'b0, freq_rd};
    match     = (freq_rd != '0) && (cum_rd <= slot) && ({1'b0, slot} < cum_end);
    x_low     = (x_q < LOWER);
    x_shift_d = {x_q[STATE_WIDTH-9:0], in_data_i};
    // slot >= cum on a match, and freq*(x>>R) + (slot-cum) < 2^32 for valid tables.
    x_dec_d   = STATE_WIDTH'(freq_rd) * (x_q >> RESOLUTION)
              + STATE_WIDTH'(slot) - STATE_WIDTH'(cum_rd);
    byte_acc  = in_valid_i && in_ready_o;
  end

  // Outputs are decoded from registered state only; no input-to-output paths.
  assign in_ready_o  = (state_q == S_INIT) || ((state_q == S_RENORM) && x_low);
  assign sym_valid_o = (state_q == S_OUT);
  assign busy_o      = (state_q != S_IDLE) && (state_q != S_ERR);
  assign sym_o       = sym_q;
  assign done_o      = done_q;
  assign err_o       = err_q;

  // Decoder FSM: init load, linear symbol search, output handshake, renormalise.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      x_q      <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      nbytes_q <= '0;
      sym_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (restart_i) begin
        state_q <= S_IDLE;
        err_q   <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start_i) begin
              if (num_symbols_i == '0) begin
                done_q <= 1'b1;
              end else begin
                cnt_q    <= num_symbols_i;
                x_q      <= '0;
                nbytes_q <= '0;
                state_q  <= S_INIT;
              end
            end
          end
          S_INIT: begin
            if (byte_acc) begin
              x_q      <= x_shift_d;
              nbytes_q <= nbytes_q + 2'd1;
              if (nbytes_q == 2'd3) begin
                idx_q   <= '0;
                state_q <= S_LOOKUP;
              end
            end
          end
          S_LOOKUP: begin
            if (match) begin
              x_q     <= x_dec_d;
              sym_q   <= idx_q;
              state_q <= S_OUT;
            end else if (idx_q == '1) begin
              err_q   <= 1'b1;
              state_q <= S_ERR;
            end else begin
              idx_q <= idx_q + IDX_ONE;
            end
          end
          S_OUT: begin
            if (sym_ready_i) begin
              cnt_q   <= cnt_q - 32'd1;
              state_q <= S_RENORM;
            end
          end
          S_RENORM: begin
            // Decision is made on the registered state, so at most one byte per cycle.
            if (x_low) begin
              if (in_valid_i) begin
                x_q <= x_shift_d;
              end
            end else if (cnt_q == '0) begin
              done_q  <= 1'b1;
              state_q <= S_IDLE;
`ifdef RANS_DEC_FINAL_CHECK_EN
              if (x_q != LOWER) begin
                err_q <= 1'b1;
              end
`endif
            end else begin
              idx_q   <= '0;
              state_q <= S_LOOKUP;
            end
          end
          S_ERR: begin
            err_q <= 1'b1;
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rans_decoder.sv
// Directed bench for rans_decoder: single decode, lookup failure, control
// corners, round trip against a reference encoder with backpressure, async reset.
module tb_rans_decoder;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       restart_i = 1'b0;
  logic       freq_wr_i = 1'b0;
  logic [7:0] freq_addr_i = '0;
  logic [9:0] freq_i = '0;
  logic [9:0] cum_freq_i = '0;
  logic       start_i = 1'b0;
  logic [31:0] num_symbols_i = '0;
  logic       in_valid_i = 1'b0;
  logic [7:0] in_data_i = '0;
  logic       in_ready_o;
  logic       sym_valid_o;
  logic [7:0] sym_o;
  logic       sym_ready_i = 1'b0;
  logic       busy_o;
  logic       done_o;
  logic       err_o;

  int tests = 0;
  int fails = 0;

  logic [7:0] in_q[$];
  logic [7:0] got_q[$];
  int acc_cnt, lookup_first, lookup_cnt;
  bit done_seen, err_seen, starved;

  always #5 clk_i = ~clk_i;

  rans_decoder dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .restart_i(restart_i),
    .freq_wr_i(freq_wr_i), .freq_addr_i(freq_addr_i), .freq_i(freq_i),
    .cum_freq_i(cum_freq_i), .start_i(start_i), .num_symbols_i(num_symbols_i),
    .in_valid_i(in_valid_i), .in_data_i(in_data_i), .in_ready_o(in_ready_o),
    .sym_valid_o(sym_valid_o), .sym_o(sym_o), .sym_ready_i(sym_ready_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic write_entry(input logic [7:0] a, input logic [9:0] f, input logic [9:0] c);
    freq_wr_i = 1'b1; freq_addr_i = a; freq_i = f; cum_freq_i = c;
    @(negedge clk_i);
    freq_wr_i = 1'b0;
  endtask

  task automatic clear_table();
    for (int i = 0; i < 256; i++) write_entry(8'(i), 10'd0, 10'd0);
  endtask

  task automatic start_dec(input logic [31:0] n);
    start_i = 1'b1; num_symbols_i = n;
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  task automatic do_restart();
    restart_i = 1'b1;
    @(negedge clk_i);
    restart_i = 1'b0;
  endtask

  task automatic load_bytes(input logic [7:0] b0, b1, b2, b3);
    in_q.delete();
    in_q.push_back(b0); in_q.push_back(b1); in_q.push_back(b2); in_q.push_back(b3);
  endtask

  // Cycle engine: feeds in_q, sinks symbols, optionally stalls one symbol.
  task automatic run_stream(input int max_cycles, input bit gaps, input int stall_sym, input int stall_len);
    int lk = 0;
    int stall_left = stall_len;
    bit holding = 0;
    logic [7:0] held = '0;
    acc_cnt = 0; lookup_first = -1; done_seen = 0; err_seen = 0; starved = 0;
    got_q.delete();
    for (int cyc = 0; cyc < max_cycles; cyc++) begin
      if (done_o) begin done_seen = 1; break; end
      if (err_o) begin err_seen = 1; break; end
      if (in_q.size() == 0 && in_ready_o && got_q.size() > 0) begin starved = 1; break; end
      if (busy_o && !in_ready_o && !sym_valid_o) lk++;
      in_valid_i = (in_q.size() > 0) && (!gaps || $urandom_range(0, 1) == 1);
      in_data_i  = (in_q.size() > 0) ? in_q[0] : 8'h00;
      sym_ready_i = 1'b0;
      if (holding && stall_left > 0) begin
        tests++;
        if (sym_valid_o !== 1'b1 || sym_o !== held)
          $display("FAIL stall_hold: got valid=%0b sym=%02h expected valid=1 sym=%02h", sym_valid_o, sym_o, held);
        tests++;
        if (in_ready_o !== 1'b0)
          $display("FAIL stall_no_accept: got in_ready=%0b expected 0", in_ready_o);
        if (sym_valid_o !== 1'b1 || sym_o !== held || in_ready_o !== 1'b0) fails++;
        stall_left--;
      end else if (sym_valid_o) begin
        if (lookup_first < 0) lookup_first = lk;
        if (got_q.size() == stall_sym && stall_left > 0 && !holding) begin
          held = sym_o; holding = 1;
        end else begin
          sym_ready_i = 1'b1;
          got_q.push_back(sym_o);
        end
      end
      if (in_valid_i && in_ready_o) begin
        void'(in_q.pop_front());
        acc_cnt++;
      end
      @(negedge clk_i);
    end
    lookup_cnt = lk;
    in_valid_i = 1'b0; sym_ready_i = 1'b0;
    tests++;
    if (!done_seen && !err_seen && !starved) begin
      fails++;
      $display("FAIL stream_timeout: got no completion expected completion within %0d cycles", max_cycles);
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (3) @(negedge clk_i);
    tests++;
    if ({in_ready_o, sym_valid_o, busy_o, done_o, err_o, sym_o} !== 13'd0) begin
      fails++;
      $display("FAIL reset_outputs: got %04h expected 0000", {in_ready_o, sym_valid_o, busy_o, done_o, err_o, sym_o});
    end
    rst_ni = 1'b1;
    @(negedge clk_i);
    tests++;
    if (busy_o !== 1'b0 || in_ready_o !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle: got busy=%0b in_ready=%0b expected 0 0", busy_o, in_ready_o);
    end
    $display("[TB] reset checked");
  endtask

  task automatic test_single_decode();
    logic exp_err;
`ifdef RANS_DEC_FINAL_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    clear_table();
    write_entry(8'h41, 10'd512, 10'd0);
    write_entry(8'h42, 10'd512, 10'd512);
    start_dec(32'd1);
    load_bytes(8'h00, 8'h80, 8'h01, 8'hFF);
    in_q.push_back(8'hAB); in_q.push_back(8'hCD);
    run_stream(2000, 1'b0, -1, 0);
    tests++;
    if (got_q.size() != 1 || got_q[0] !== 8'h41) begin
      fails++;
      $display("FAIL single_sym: got n=%0d sym=%02h expected n=1 sym=41", got_q.size(), got_q.size() ? got_q[0] : 8'h00);
    end
    tests++;
    if (lookup_first != 66) begin
      fails++;
      $display("FAIL single_latency: got %0d expected 66", lookup_first);
    end
    tests++;
    if (acc_cnt != 5 || !done_seen) begin
      fails++;
      $display("FAIL single_bytes: got accepted=%0d done=%0b expected 5 1", acc_cnt, done_seen);
    end
    tests++;
    if (err_o !== exp_err) begin
      fails++;
      $display("FAIL single_final_err: got %0b expected %0b", err_o, exp_err);
    end
    @(negedge clk_i);
    tests++;
    if (done_o !== 1'b0) begin
      fails++;
      $display("FAIL done_pulse_width: got %0b expected 0", done_o);
    end
    $display("[TB] single decode: sym=%02h latency=%0d bytes=%0d", got_q.size() ? got_q[0] : 8'h00, lookup_first, acc_cnt);
    do_restart();
  endtask

  task automatic test_lookup_fail();
    clear_table();
    write_entry(8'h41, 10'd256, 10'd0);
    start_dec(32'd1);
    load_bytes(8'h00, 8'h80, 8'h01, 8'hFF);
    run_stream(2000, 1'b0, -1, 0);
    tests++;
    if (!err_seen || lookup_cnt != 256) begin
      fails++;
      $display("FAIL lookup_fail: got err=%0b cycles=%0d expected 1 256", err_seen, lookup_cnt);
    end
    tests++;
    if (in_ready_o !== 1'b0 || busy_o !== 1'b0 || sym_valid_o !== 1'b0) begin
      fails++;
      $display("FAIL err_outputs: got ready=%0b busy=%0b valid=%0b expected 0 0 0", in_ready_o, busy_o, sym_valid_o);
    end
    do_restart();
    tests++;
    if (err_o !== 1'b0 || busy_o !== 1'b0) begin
      fails++;
      $display("FAIL err_restart: got err=%0b busy=%0b expected 0 0", err_o, busy_o);
    end
    $display("[TB] lookup failure: err after %0d cycles", lookup_cnt);
  endtask

  task automatic test_control_corners();
    // zero-symbol start: done next cycle, nothing consumed
    in_valid_i = 1'b1; in_data_i = 8'h55;
    start_dec(32'd0);
    tests++;
    if (done_o !== 1'b1 || in_ready_o !== 1'b0 || busy_o !== 1'b0) begin
      fails++;
      $display("FAIL zero_count: got done=%0b ready=%0b busy=%0b expected 1 0 0", done_o, in_ready_o, busy_o);
    end
    @(negedge clk_i);
    in_valid_i = 1'b0;
    tests++;
    if (done_o !== 1'b0) begin
      fails++;
      $display("FAIL zero_count_pulse: got %0b expected 0", done_o);
    end
    $display("[TB] zero-count start checked");
    // restart while renormalising
    write_entry(8'h41, 10'd512, 10'd0);
    write_entry(8'h42, 10'd512, 10'd512);
    start_dec(32'd1);
    load_bytes(8'h00, 8'h80, 8'h01, 8'hFF);
    run_stream(2000, 1'b0, -1, 0);
    tests++;
    if (!starved || in_ready_o !== 1'b1) begin
      fails++;
      $display("FAIL renorm_reach: got starved=%0b ready=%0b expected 1 1", starved, in_ready_o);
    end
    in_valid_i = 1'b1; in_data_i = 8'hAB;
    do_restart();
    in_valid_i = 1'b0;
    tests++;
    if (busy_o !== 1'b0 || in_ready_o !== 1'b0 || sym_valid_o !== 1'b0 || err_o !== 1'b0) begin
      fails++;
      $display("FAIL restart_renorm: got busy=%0b ready=%0b valid=%0b err=%0b expected 0 0 0 0", busy_o, in_ready_o, sym_valid_o, err_o);
    end
    // write while busy is dropped; retained table still decodes 0x41
    start_dec(32'd1);
    write_entry(8'h41, 10'd0, 10'd0);
    load_bytes(8'h00, 8'h80, 8'h01, 8'hFF);
    in_q.push_back(8'hAB);
    run_stream(2000, 1'b0, -1, 0);
    tests++;
    if (!done_seen || got_q.size() != 1 || got_q[0] !== 8'h41) begin
      fails++;
      $display("FAIL busy_write_ignored: got done=%0b n=%0d sym=%02h expected 1 1 41", done_seen, got_q.size(), got_q.size() ? got_q[0] : 8'h00);
    end
    $display("[TB] restart/retained-table decode: n=%0d", got_q.size());
    do_restart();
  endtask

  task automatic test_round_trip_backpressure();
    int ftab [4] = '{400, 300, 200, 124};
    int ctab [4] = '{0, 400, 700, 900};
    logic [7:0] exp_q[$];
    longint unsigned x, xmax, f, c;
    int unsigned seed = 32'h1234_5678;
    int nbytes;
    clear_table();
    for (int k = 0; k < 4; k++) write_entry(8'(8'h10 + k), 10'(ftab[k]), 10'(ctab[k]));
    for (int i = 0; i < 64; i++) begin
      seed = seed * 32'd1103515245 + 32'd12345;
      exp_q.push_back(8'(8'h10 + ((seed >> 16) & 3)));
    end
    // reference encoder: symbols last-to-first, bytes prepended so the stream reads head-first
    in_q.delete();
    x = 64'h0080_0000;
    for (int i = 63; i >= 0; i--) begin
      f = longint'(ftab[exp_q[i] - 8'h10]);
      c = longint'(ctab[exp_q[i] - 8'h10]);
      xmax = 64'd2097152 * f;
      while (x >= xmax) begin
        in_q.push_front(8'(x));
        x = x >> 8;
      end
      x = ((x / f) << 10) + (x % f) + c;
    end
    for (int k = 0; k < 4; k++) begin
      in_q.push_front(8'(x));
      x = x >> 8;
    end
    nbytes = in_q.size();
    start_dec(32'd64);
    run_stream(30000, 1'b1, 5, 10);
    tests++;
    if (!done_seen || got_q.size() != 64) begin
      fails++;
      $display("FAIL rt_count: got done=%0b n=%0d expected 1 64", done_seen, got_q.size());
    end
    for (int i = 0; i < 64 && i < got_q.size(); i++) begin
      tests++;
      if (got_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL rt_sym[%0d]: got %02h expected %02h", i, got_q[i], exp_q[i]);
      end
    end
    tests++;
    if (acc_cnt != nbytes || err_o !== 1'b0) begin
      fails++;
      $display("FAIL rt_bytes_err: got bytes=%0d err=%0b expected %0d 0", acc_cnt, err_o, nbytes);
    end
    $display("[TB] round trip: %0d symbols from %0d bytes", got_q.size(), acc_cnt);
  endtask

  task automatic test_async_reset();
    do_restart();
    start_dec(32'd1);
    load_bytes(8'h00, 8'h80, 8'h01, 8'hFF);
    for (int k = 0; k < 4; k++) begin
      in_valid_i = 1'b1; in_data_i = in_q[k];
      @(negedge clk_i);
    end
    in_valid_i = 1'b0;
    repeat (5) @(negedge clk_i);
    tests++;
    if (busy_o !== 1'b1 || in_ready_o !== 1'b0 || sym_valid_o !== 1'b0) begin
      fails++;
      $display("FAIL pre_reset_lookup: got busy=%0b ready=%0b valid=%0b expected 1 0 0", busy_o, in_ready_o, sym_valid_o);
    end
    #2 rst_ni = 1'b0;
    #1;
    tests++;
    if ({in_ready_o, sym_valid_o, busy_o, done_o, err_o, sym_o} !== 13'd0) begin
      fails++;
      $display("FAIL async_reset: got %04h expected 0000", {in_ready_o, sym_valid_o, busy_o, done_o, err_o, sym_o});
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    $display("[TB] async reset checked");
  endtask

  initial begin
    @(negedge clk_i);
    test_reset();
    test_single_decode();
    test_lookup_fail();
    test_control_corners();
    test_round_trip_backpressure();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
